// File: rtl/trap_pkg.sv
// trap_pkg: shared state encoding and constants for the interrupt/trap sequencer
package trap_pkg;
   typedef enum logic [2:0] {IDLE, DRAIN, SAVE, VECTOR, RET} state_t;
   localparam logic [1:0] PC_SEL_SEQ = 2'b00;
   localparam logic [1:0] PC_SEL_VEC = 2'b01;
   localparam logic [1:0] PC_SEL_EPC = 2'b10;
   localparam int CAUSE_INT_BIT = 31;
endpackage

// File: rtl/irq_trap_seq_drain_timer.sv
// drain_timer: counts DRAIN cycles and flags the last one allowed before an abort
module drain_timer #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic clrn,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = $clog2(LIMIT);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);
   logic [W-1:0] cnt;
   // cleared while idle so each drain starts counting from zero
   always_ff @(posedge clk)
      if (!clrn || clear) cnt <= '0;
      else if (enable) cnt <= cnt + 1'b1;
   assign expired = cnt == LAST;
endmodule

// File: rtl/irq_trap_seq.sv
// irq_trap_seq: machine-mode interrupt entry, FPU drain and mret return sequencer
module irq_trap_seq
   import trap_pkg::*;
#(
   parameter logic [31:0] TRAP_VEC    = 32'h0000_0008,
   parameter int          DRAIN_LIMIT = 64,
   parameter int          CAUSE_W     = 5
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic               irq,
   input  logic [CAUSE_W-1:0] irq_cause,
   input  logic [31:0]        pc_ex,
   input  logic               fpu_busy,
   input  logic               mret,
   input  logic               csr_wr_mie,
   input  logic               csr_mie_val,
   output logic               stall,
   output logic               flush,
   output logic [1:0]         pc_sel,
   output logic [31:0]        vec_pc,
   output logic               epc_we,
   output logic               cause_we,
   output logic [31:0]        epc_d,
   output logic [31:0]        cause_d,
   output logic               fpu_abort,
   output logic               int_ack,
   output logic               mie_o,
   output logic               mpie_o
);
   state_t state, state_nx;
   logic [31:0] epc_l;
   logic [CAUSE_W-1:0] cause_l;
   logic mie, mpie, expired, take;
   assign take = state == IDLE && !mret && irq && mie;
   drain_timer #(.LIMIT(DRAIN_LIMIT)) u_timer (
      .clk(clk), .clrn(clrn), .clear(state == IDLE), .enable(state == DRAIN), .expired(expired)
   );
   // state register
   always_ff @(posedge clk)
      if (!clrn) state <= IDLE;
      else state <= state_nx;
   // next state: mret beats irq, drain ends on FPU idle or timeout
   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:    state_nx = mret ? RET : take ? DRAIN : IDLE;
         DRAIN:   state_nx = (!fpu_busy || expired) ? SAVE : DRAIN;
         SAVE:    state_nx = VECTOR;
         default: state_nx = IDLE;
      endcase
   end
   // capture resume point and cause at the moment the interrupt is accepted
   always_ff @(posedge clk)
      if (!clrn) begin
         epc_l   <= '0;
         cause_l <= '0;
      end else if (take) begin
         epc_l   <= pc_ex;
         cause_l <= irq_cause;
      end
   // status bits: trap entry/return override CSR writes, which apply only in IDLE
   always_ff @(posedge clk)
      if (!clrn) begin
         mie  <= 1'b0;
         mpie <= 1'b0;
      end else if (state == SAVE) begin
         mpie <= mie;
         mie  <= 1'b0;
      end else if (state == RET) begin
         mie  <= mpie;
         mpie <= 1'b1;
      end else if (state == IDLE && !mret && csr_wr_mie) mie <= csr_mie_val;
   // Moore outputs, except the abort which reacts to fpu_busy in the final DRAIN cycle
   always_comb begin
      stall     = state == DRAIN || state == SAVE;
      flush     = state == VECTOR || state == RET;
      pc_sel    = state == VECTOR ? PC_SEL_VEC : state == RET ? PC_SEL_EPC : PC_SEL_SEQ;
      epc_we    = state == SAVE;
      cause_we  = state == SAVE;
      int_ack   = state == VECTOR;
      fpu_abort = state == DRAIN && fpu_busy && expired;
      epc_d     = epc_l;
      cause_d   = state == SAVE ? (32'(cause_l) | (32'd1 << CAUSE_INT_BIT)) : 32'd0;
   end
   assign vec_pc = TRAP_VEC;
   assign mie_o  = mie;
   assign mpie_o = mpie;
endmodule

// File: tb/tb_irq_trap_seq.sv
// tb_irq_trap_seq: directed self-checking bench for the interrupt/trap sequencer
module tb_irq_trap_seq;
   logic clk = 1'b0, clrn = 1'b0, irq = 1'b0, fpu_busy = 1'b0, mret = 1'b0;
   logic csr_wr_mie = 1'b0, csr_mie_val = 1'b0;
   logic [4:0] irq_cause = '0;
   logic [31:0] pc_ex = '0;
   logic stall, flush, epc_we, cause_we, fpu_abort, int_ack, mie_o, mpie_o;
   logic [1:0] pc_sel;
   logic [31:0] vec_pc, epc_d, cause_d;
   logic stall_b, flush_b, epc_we_b, cause_we_b, fpu_abort_b, int_ack_b, mie_b, mpie_b;
   logic [1:0] pc_sel_b;
   logic [31:0] vec_pc_b, epc_d_b, cause_d_b;
   int errors = 0, checks = 0;
   wire [9:0] obs   = {stall, flush, pc_sel, epc_we, cause_we, fpu_abort, int_ack, mie_o, mpie_o};
   wire [9:0] obs_b = {stall_b, flush_b, pc_sel_b, epc_we_b, cause_we_b, fpu_abort_b, int_ack_b, mie_b, mpie_b};

   irq_trap_seq dut (
      .clk(clk), .clrn(clrn), .irq(irq), .irq_cause(irq_cause), .pc_ex(pc_ex),
      .fpu_busy(fpu_busy), .mret(mret), .csr_wr_mie(csr_wr_mie), .csr_mie_val(csr_mie_val),
      .stall(stall), .flush(flush), .pc_sel(pc_sel), .vec_pc(vec_pc), .epc_we(epc_we),
      .cause_we(cause_we), .epc_d(epc_d), .cause_d(cause_d), .fpu_abort(fpu_abort),
      .int_ack(int_ack), .mie_o(mie_o), .mpie_o(mpie_o)
   );

   irq_trap_seq #(.DRAIN_LIMIT(4)) dut_b (
      .clk(clk), .clrn(clrn), .irq(irq), .irq_cause(irq_cause), .pc_ex(pc_ex),
      .fpu_busy(fpu_busy), .mret(mret), .csr_wr_mie(csr_wr_mie), .csr_mie_val(csr_mie_val),
      .stall(stall_b), .flush(flush_b), .pc_sel(pc_sel_b), .vec_pc(vec_pc_b), .epc_we(epc_we_b),
      .cause_we(cause_we_b), .epc_d(epc_d_b), .cause_d(cause_d_b), .fpu_abort(fpu_abort_b),
      .int_ack(int_ack_b), .mie_o(mie_b), .mpie_o(mpie_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mie();
      csr_wr_mie = 1'b1;
      csr_mie_val = 1'b1;
      tick();
      csr_wr_mie = 1'b0;
      csr_mie_val = 1'b0;
   endtask

   task automatic test_reset();
      clrn = 1'b0;
      tick();
      tick();
      checks++;
      if (obs !== 10'b0) begin errors++; $display("FAIL reset_outputs obs=%b exp=%b", obs, 10'b0); end
      checks++;
      if (epc_d !== 32'd0 || cause_d !== 32'd0) begin errors++; $display("FAIL reset_data epc_d=%h cause_d=%h exp=0", epc_d, cause_d); end
      checks++;
      if (vec_pc !== 32'h8) begin errors++; $display("FAIL reset_vec vec_pc=%h exp=%h", vec_pc, 32'h8); end
      clrn = 1'b1;
   endtask

   task automatic test_irq_idle();
      set_mie();
      checks++;
      if (obs !== 10'b0000000010) begin errors++; $display("FAIL csr_mie obs=%b exp=%b", obs, 10'b0000000010); end
      irq = 1'b1; irq_cause = 5'd11; pc_ex = 32'h100;
      tick();
      checks++;
      if (obs !== 10'b1000000010) begin errors++; $display("FAIL irq_drain obs=%b exp=%b", obs, 10'b1000000010); end
      irq = 1'b0; irq_cause = 5'd3; pc_ex = 32'h200;
      tick();
      checks++;
      if (obs !== 10'b1000110010) begin errors++; $display("FAIL irq_save obs=%b exp=%b", obs, 10'b1000110010); end
      checks++;
      if (epc_d !== 32'h100 || cause_d !== 32'h8000_000B) begin errors++; $display("FAIL irq_save_data epc_d=%h cause_d=%h exp=100/8000000b", epc_d, cause_d); end
      tick();
      checks++;
      if (obs !== 10'b0101000101) begin errors++; $display("FAIL irq_vector obs=%b exp=%b", obs, 10'b0101000101); end
      tick();
      checks++;
      if (obs !== 10'b0000000001) begin errors++; $display("FAIL irq_idle_after obs=%b exp=%b", obs, 10'b0000000001); end
   endtask

   task automatic test_fpu_drain();
      set_mie();
      irq = 1'b1; irq_cause = 5'd7; pc_ex = 32'h200; fpu_busy = 1'b1;
      tick();
      irq = 1'b0;
      for (int i = 0; i < 5; i++) begin
         fpu_busy = i < 4;
         #1;
         checks++;
         if (obs !== 10'b1000000011) begin errors++; $display("FAIL drain_cycle%0d obs=%b exp=%b", i, obs, 10'b1000000011); end
         tick();
      end
      fpu_busy = 1'b0;
      checks++;
      if (obs !== 10'b1000110011) begin errors++; $display("FAIL drain_save obs=%b exp=%b", obs, 10'b1000110011); end
      checks++;
      if (epc_d !== 32'h200 || cause_d !== 32'h8000_0007) begin errors++; $display("FAIL drain_save_data epc_d=%h cause_d=%h exp=200/80000007", epc_d, cause_d); end
      tick();
      checks++;
      if (obs !== 10'b0101000101) begin errors++; $display("FAIL drain_vector obs=%b exp=%b", obs, 10'b0101000101); end
      tick();
   endtask

   task automatic test_drain_timeout();
      set_mie();
      irq = 1'b1; irq_cause = 5'd2; pc_ex = 32'h300; fpu_busy = 1'b1;
      tick();
      irq = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (obs_b !== (i == 3 ? 10'b1000001011 : 10'b1000000011)) begin
            errors++;
            $display("FAIL timeout_cycle%0d obs=%b exp=%b", i, obs_b, (i == 3 ? 10'b1000001011 : 10'b1000000011));
         end
         tick();
      end
      checks++;
      if (obs_b !== 10'b1000110011) begin errors++; $display("FAIL timeout_save obs=%b exp=%b", obs_b, 10'b1000110011); end
      checks++;
      if (cause_d_b !== 32'h8000_0002) begin errors++; $display("FAIL timeout_cause cause_d=%h exp=80000002", cause_d_b); end
      fpu_busy = 1'b0;
      tick();
      tick();
      tick();
      tick();
   endtask

   task automatic test_mret_irq();
      set_mie();
      mret = 1'b1; irq = 1'b1; irq_cause = 5'd4; pc_ex = 32'h400; csr_wr_mie = 1'b1; csr_mie_val = 1'b0;
      tick();
      mret = 1'b0; csr_wr_mie = 1'b0;
      checks++;
      if (obs !== 10'b0110000011) begin errors++; $display("FAIL mret_ret obs=%b exp=%b", obs, 10'b0110000011); end
      checks++;
      if (epc_d !== 32'h300) begin errors++; $display("FAIL mret_epc epc_d=%h exp=300", epc_d); end
      tick();
      checks++;
      if (obs !== 10'b0000000011) begin errors++; $display("FAIL mret_idle obs=%b exp=%b", obs, 10'b0000000011); end
      tick();
      checks++;
      if (obs !== 10'b1000000011) begin errors++; $display("FAIL mret_then_irq obs=%b exp=%b", obs, 10'b1000000011); end
      irq = 1'b0;
      tick();
      checks++;
      if (epc_d !== 32'h400 || cause_d !== 32'h8000_0004) begin errors++; $display("FAIL mret_irq_save epc_d=%h cause_d=%h exp=400/80000004", epc_d, cause_d); end
      tick();
      tick();
   endtask

   task automatic test_masked();
      irq = 1'b1; irq_cause = 5'd9; pc_ex = 32'h500;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== 10'b0000000001) begin errors++; $display("FAIL masked_wait%0d obs=%b exp=%b", i, obs, 10'b0000000001); end
      end
      set_mie();
      checks++;
      if (obs !== 10'b0000000011) begin errors++; $display("FAIL masked_enable obs=%b exp=%b", obs, 10'b0000000011); end
      tick();
      checks++;
      if (obs !== 10'b1000000011) begin errors++; $display("FAIL masked_taken obs=%b exp=%b", obs, 10'b1000000011); end
      irq = 1'b0;
      tick();
      checks++;
      if (epc_d !== 32'h500 || cause_d !== 32'h8000_0009) begin errors++; $display("FAIL masked_save epc_d=%h cause_d=%h exp=500/80000009", epc_d, cause_d); end
      tick();
      tick();
   endtask

   task automatic test_reset_drain();
      set_mie();
      irq = 1'b1; irq_cause = 5'd1; pc_ex = 32'h600; fpu_busy = 1'b1;
      tick();
      checks++;
      if (obs !== 10'b1000000011) begin errors++; $display("FAIL rst_drain_enter obs=%b exp=%b", obs, 10'b1000000011); end
      clrn = 1'b0;
      tick();
      checks++;
      if (obs !== 10'b0) begin errors++; $display("FAIL rst_drain_idle obs=%b exp=%b", obs, 10'b0); end
      clrn = 1'b1; irq = 1'b0; fpu_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== 10'b0 || epc_d !== 32'd0) begin errors++; $display("FAIL rst_drain_after%0d obs=%b epc_d=%h exp=0", i, obs, epc_d); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_irq_idle();
      test_fpu_drain();
      test_drain_timeout();
      test_mret_irq();
      test_masked();
      test_reset_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
